eq_band_mixer: RTL and testbench

- Recombination stage of the digital equalizer: takes the ten per-band outputs of the FIR filter bank and produces one 24-bit output sample.
- Each band is weighted by a programmable signed gain and summed by one time-multiplexed multiply-accumulate unit.
- Runs once per audio sample strobe; the result is rounded and (optionally) saturated.
- Sits directly downstream of the filter bank, in front of the audio output path.

---
 rtl/eq_mixer_pkg.sv | 34 +++
 rtl/eq_gain_bank.sv | 46 ++++
 rtl/eq_band_mixer.sv | 177 +++++++++++++++++
 tb/tb_eq_band_mixer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/eq_mixer_pkg.sv
// Shared widths, types and FSM encoding for the equalizer band mixer.
package eq_mixer_pkg;

    localparam int unsigned NUM_BANDS = 10;
    localparam int unsigned SAMPLE_W  = 24;
    localparam int unsigned GAIN_W    = 16;
    localparam int unsigned GAIN_FRAC = 14;
    localparam int unsigned ACC_W     = 44;
    localparam int unsigned PROD_W    = SAMPLE_W + GAIN_W;
    localparam int unsigned ADDR_W    = 4;
    localparam int unsigned IDX_W     = 4;

    localparam logic [GAIN_W-1:0] GAIN_UNITY = 16'h4000;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic signed [GAIN_W-1:0]   gain_t;
    typedef logic signed [PROD_W-1:0]   prod_t;
    typedef logic signed [ACC_W-1:0]    acc_t;

    // Half an LSB of the output, added before the arithmetic shift (round half up)
    localparam acc_t ROUND_BIAS = ACC_W'(2 ** (GAIN_FRAC - 1));

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        ROUND = 2'd2
    } state_e;

    // Sign-extend a full product into the accumulator width
    function automatic acc_t widen_prod(input prod_t p);
        return {{(ACC_W - PROD_W){p[PROD_W-1]}}, p};
    endfunction

endpackage

// File: rtl/eq_gain_bank.sv
// Per-band gain register file: resets to unity, one write port, snapshot output.
module eq_gain_bank
    import eq_mixer_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_en,
    input  logic [ADDR_W-1:0]           wr_addr,
    input  logic [GAIN_W-1:0]           wr_data,
    output logic [NUM_BANDS*GAIN_W-1:0] gains
);

    gain_t gain_q [NUM_BANDS];
    gain_t gain_d [NUM_BANDS];

    // Write decode; addresses past the last band match no entry and are dropped
    always_comb begin
        for (int unsigned i = 0; i < NUM_BANDS; i++) begin
            gain_d[i] = gain_q[i];
            if (wr_en && (wr_addr == ADDR_W'(i))) begin
                gain_d[i] = wr_data;
            end
        end
    end

    // Gain registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_BANDS; i++) begin
                gain_q[i] <= GAIN_UNITY;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_BANDS; i++) begin
                gain_q[i] <= gain_d[i];
            end
        end
    end

    // Flatten the register file for the snapshot port
    always_comb begin
        for (int unsigned i = 0; i < NUM_BANDS; i++) begin
            gains[i*GAIN_W +: GAIN_W] = gain_q[i];
        end
    end

endmodule

// File: rtl/eq_band_mixer.sv
// Weighted recombination of the filter-bank bands into one output sample.
// A single multiply-accumulate walks the ten bands, then one rounding cycle.
// Build option: EQ_MIXER_SAT_EN selects a saturating output (clip reports it);
// without it the rounded result wraps and clip stays low.
module eq_band_mixer
    import eq_mixer_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          sample_valid,
    input  logic [NUM_BANDS*SAMPLE_W-1:0] band_in,
    input  logic                          gain_wr_en,
    input  logic [ADDR_W-1:0]             gain_wr_addr,
    input  logic [GAIN_W-1:0]             gain_wr_data,
    input  logic                          overrun_clr,
    output logic [SAMPLE_W-1:0]           audio_out,
    output logic                          out_valid,
    output logic                          clip,
    output logic                          busy,
    output logic                          overrun
);

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    acc_t                  acc_q, acc_d;
    sample_t               band_q [NUM_BANDS];
    sample_t               band_d [NUM_BANDS];
    gain_t                 gain_work_q [NUM_BANDS];
    gain_t                 gain_work_d [NUM_BANDS];
    logic [SAMPLE_W-1:0]   audio_q, audio_d;
    logic                  out_valid_q, out_valid_d;
    logic                  clip_q, clip_d;
    logic                  busy_q, busy_d;
    logic                  overrun_q, overrun_d;

    logic [NUM_BANDS*GAIN_W-1:0] gain_bank;
    prod_t                       prod;
    acc_t                        acc_rnd;
    logic [SAMPLE_W-1:0]         res_audio;
    logic                        res_clip;

    eq_gain_bank u_gain_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (gain_wr_en),
        .wr_addr (gain_wr_addr),
        .wr_data (gain_wr_data),
        .gains   (gain_bank)
    );

    // Current band times its snapshot gain, then the rounding bias on the accumulator
    always_comb begin
        prod    = PROD_W'(band_q[idx_q]) * PROD_W'(gain_work_q[idx_q]);
        acc_rnd = acc_q + ROUND_BIAS;
    end

`ifdef EQ_MIXER_SAT_EN
    acc_t                    acc_shr;
    logic [ACC_W-SAMPLE_W:0] shr_hi;

    // Clamp when the bits above the output sign are not a pure sign extension
    always_comb begin
        acc_shr   = acc_rnd >>> GAIN_FRAC;
        shr_hi    = acc_shr[ACC_W-1:SAMPLE_W-1];
        res_clip  = (shr_hi != '0) && (shr_hi != '1);
        res_audio = acc_shr[SAMPLE_W-1:0];
        if (res_clip) begin
            res_audio = acc_shr[ACC_W-1] ? {1'b1, {(SAMPLE_W-1){1'b0}}}
                                         : {1'b0, {(SAMPLE_W-1){1'b1}}};
        end
    end
`else
    // Two's-complement wrap of the rounded result
    always_comb begin
        res_audio = SAMPLE_W'(acc_rnd >>> GAIN_FRAC);
        res_clip  = 1'b0;
    end
`endif

    // Next-state and datapath control
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        audio_d     = audio_q;
        out_valid_d = 1'b0;
        clip_d      = 1'b0;
        overrun_d   = overrun_q;
        for (int unsigned i = 0; i < NUM_BANDS; i++) begin
            band_d[i]      = band_q[i];
            gain_work_d[i] = gain_work_q[i];
        end

        // Set takes priority over clear
        if (overrun_clr) begin
            overrun_d = 1'b0;
        end
        if (enable && sample_valid && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sample_valid) begin
                        for (int unsigned i = 0; i < NUM_BANDS; i++) begin
                            band_d[i]      = band_in[i*SAMPLE_W +: SAMPLE_W];
                            gain_work_d[i] = gain_bank[i*GAIN_W +: GAIN_W];
                        end
                        acc_d   = '0;
                        idx_d   = '0;
                        state_d = MAC;
                    end
                end
                MAC: begin
                    acc_d = acc_q + widen_prod(prod);
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(NUM_BANDS - 1)) begin
                        state_d = ROUND;
                    end
                end
                ROUND: begin
                    audio_d     = res_audio;
                    clip_d      = res_clip;
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            acc_q       <= '0;
            audio_q     <= '0;
            out_valid_q <= 1'b0;
            clip_q      <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            for (int unsigned i = 0; i < NUM_BANDS; i++) begin
                band_q[i]      <= '0;
                gain_work_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            audio_q     <= audio_d;
            out_valid_q <= out_valid_d;
            clip_q      <= clip_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
            for (int unsigned i = 0; i < NUM_BANDS; i++) begin
                band_q[i]      <= band_d[i];
                gain_work_q[i] <= gain_work_d[i];
            end
        end
    end

    assign audio_out = audio_q;
    assign out_valid = out_valid_q;
    assign clip      = clip_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_eq_band_mixer.sv
// Directed self-checking bench for eq_band_mixer (either EQ_MIXER_SAT_EN build).
module tb_eq_band_mixer;

    localparam int NB = 10;
    localparam int SW = 24;
    localparam int GW = 16;

    logic               clk;
    logic               rst_n;
    logic               enable;
    logic               sample_valid;
    logic [NB*SW-1:0]   band_in;
    logic               gain_wr_en;
    logic [3:0]         gain_wr_addr;
    logic [GW-1:0]      gain_wr_data;
    logic               overrun_clr;
    logic [SW-1:0]      audio_out;
    logic               out_valid;
    logic               clip;
    logic               busy;
    logic               overrun;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    eq_band_mixer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .sample_valid (sample_valid),
        .band_in      (band_in),
        .gain_wr_en   (gain_wr_en),
        .gain_wr_addr (gain_wr_addr),
        .gain_wr_data (gain_wr_data),
        .overrun_clr  (overrun_clr),
        .audio_out    (audio_out),
        .out_valid    (out_valid),
        .clip         (clip),
        .busy         (busy),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    function automatic logic [NB*SW-1:0] fill(input logic [SW-1:0] v);
        logic [NB*SW-1:0] r;
        for (int i = 0; i < NB; i++) r[i*SW +: SW] = v;
        return r;
    endfunction

    function automatic logic [NB*SW-1:0] put(input logic [NB*SW-1:0] b, input int i,
                                             input logic [SW-1:0] v);
        logic [NB*SW-1:0] r;
        r = b;
        r[i*SW +: SW] = v;
        return r;
    endfunction

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic set_gain(input int addr, input logic [GW-1:0] data);
        gain_wr_en   = 1'b1;
        gain_wr_addr = 4'(addr);
        gain_wr_data = data;
        step();
        gain_wr_en   = 1'b0;
    endtask

    // Strobe in cycle T; returns during cycle T+1 (cyc = 1)
    task automatic start_strobe(input logic [NB*SW-1:0] bands);
        band_in      = bands;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        cyc = 1;
    endtask

    // Wait (bounded) for out_valid; lat = cycle offset from the strobe, -1 on timeout
    task automatic wait_out(output int lat);
        lat = -1;
        for (int i = 0; i < 25; i++) begin
            if (out_valid) begin
                lat = cyc;
                break;
            end
            step();
        end
    endtask

    int lat;
    int pulses;
    logic [SW-1:0] exp_hi, exp_lo;
    logic          exp_clip;

    initial begin
        rst_n = 1'b0; enable = 1'b0; sample_valid = 1'b0; band_in = '0;
        gain_wr_en = 1'b0; gain_wr_addr = '0; gain_wr_data = '0; overrun_clr = 1'b0;
        step(); step(); step();

        // Reset values
        check("rst_audio",   32'(audio_out), 32'h0);
        check("rst_valid",   32'(out_valid), 32'h0);
        check("rst_clip",    32'(clip),      32'h0);
        check("rst_busy",    32'(busy),      32'h0);
        check("rst_overrun", 32'(overrun),   32'h0);
        rst_n = 1'b1;
        enable = 1'b1;
        step();

        // Out-of-range writes must not touch any band
        set_gain(10, 16'h0000);
        set_gain(15, 16'h0000);

        // Unity gains, all bands 0x100 -> 10 * 0x100
        start_strobe(fill(24'h000100));
        check("t1_busy_t1", 32'(busy), 32'h1);
        wait_out(lat);
        check("t1_latency", 32'(lat), 32'd12);
        check("t1_audio",   32'(audio_out), 32'h000A00);
        check("t1_clip",    32'(clip), 32'h0);
        check("t1_busy_t12", 32'(busy), 32'h0);
        step();
        check("t1_pulse_one", 32'(out_valid), 32'h0);
        check("t1_hold",      32'(audio_out), 32'h000A00);

        // Single band at half gain
        for (int i = 0; i < NB; i++) set_gain(i, (i == 3) ? 16'h2000 : 16'h0000);
        start_strobe(put(fill(24'h7FFFFF), 3, 24'h100000));
        wait_out(lat);
        check("t2_audio", 32'(audio_out), 32'h080000);

        // Rounding at the half-LSB boundary, both signs
        set_gain(0, 16'h0001);
        set_gain(3, 16'h0000);
        start_strobe(put(fill(24'h7FFFFF), 0, 24'h002000));
        wait_out(lat);
        check("t3_half_up", 32'(audio_out), 32'h000001);
        start_strobe(put(fill(24'h7FFFFF), 0, 24'h001FFF));
        wait_out(lat);
        check("t3_below_half", 32'(audio_out), 32'h000000);
        start_strobe(put(fill(24'h7FFFFF), 0, 24'hFFE000));
        wait_out(lat);
        check("t3_neg_half", 32'(audio_out), 32'h000000);
        start_strobe(put(fill(24'h7FFFFF), 0, 24'hFFDFFF));
        wait_out(lat);
        check("t3_neg_below", 32'(audio_out), 32'hFFFFFF);

        // Full-scale inputs at maximum gain
`ifdef EQ_MIXER_SAT_EN
        exp_hi = 24'h7FFFFF; exp_lo = 24'h800000; exp_clip = 1'b1;
`else
        exp_hi = 24'hFFEBEC; exp_lo = 24'h001400; exp_clip = 1'b0;
`endif
        for (int i = 0; i < NB; i++) set_gain(i, 16'h7FFF);
        start_strobe(fill(24'h7FFFFF));
        wait_out(lat);
        check("t4_pos_audio", 32'(audio_out), 32'(exp_hi));
        check("t4_pos_clip",  32'(clip), 32'(exp_clip));
        start_strobe(fill(24'h800000));
        wait_out(lat);
        check("t4_neg_audio", 32'(audio_out), 32'(exp_lo));
        check("t4_neg_clip",  32'(clip), 32'(exp_clip));

        // Strobe while busy: dropped, overrun set
        for (int i = 0; i < NB; i++) set_gain(i, 16'h4000);
        start_strobe(fill(24'h000100));
        step(); step(); step(); step();
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        wait_out(lat);
        check("t5_latency", 32'(lat), 32'd12);
        check("t5_audio",   32'(audio_out), 32'h000A00);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (out_valid) pulses++;
        end
        check("t5_extra_pulses", 32'(pulses), 32'd0);
        check("t5_overrun", 32'(overrun), 32'h1);
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        check("t5_overrun_clr", 32'(overrun), 32'h0);

        // Set and clear in the same cycle: set wins
        start_strobe(fill(24'h000100));
        step();
        sample_valid = 1'b1;
        overrun_clr  = 1'b1;
        step();
        sample_valid = 1'b0;
        overrun_clr  = 1'b0;
        check("t5_set_wins", 32'(overrun), 32'h1);
        wait_out(lat);
        check("t5b_latency", 32'(lat), 32'd12);
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;

        // Gain write mid-sample uses the snapshot
        start_strobe(fill(24'h000100));
        step(); step();
        gain_wr_en = 1'b1; gain_wr_addr = 4'd0; gain_wr_data = 16'h0000;
        step();
        gain_wr_en = 1'b0;
        wait_out(lat);
        check("t6_snapshot_lat", 32'(lat), 32'd12);
        check("t6_snapshot",     32'(audio_out), 32'h000A00);
        start_strobe(fill(24'h000100));
        wait_out(lat);
        check("t6_new_gain", 32'(audio_out), 32'h000900);

        // Enable drop mid-sample: discarded, busy low next cycle
        step();
        start_strobe(fill(24'h000200));
        step(); step(); step(); step(); step();
        enable = 1'b0;
        step();
        check("t6_busy_off", 32'(busy), 32'h0);
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (out_valid) pulses++;
        end
        check("t6_no_out", 32'(pulses), 32'd0);
        check("t6_hold",   32'(audio_out), 32'h000900);
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        step();
        check("t6_dis_overrun", 32'(overrun), 32'h0);
        check("t6_dis_busy",    32'(busy), 32'h0);
        enable = 1'b1;
        step();

        // Reset mid-operation restores unity gains and clears outputs
        start_strobe(fill(24'h000100));
        step(); step();
        rst_n = 1'b0;
        #1;
        check("t7_rst_busy",  32'(busy), 32'h0);
        check("t7_rst_audio", 32'(audio_out), 32'h0);
        step();
        rst_n = 1'b1;
        step();
        start_strobe(fill(24'h000100));
        wait_out(lat);
        check("t7_latency", 32'(lat), 32'd12);
        check("t7_unity",   32'(audio_out), 32'h000A00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
